// File: rtl/dummy_arbiter.sv
// Round-robin arbiter sharing one coprocessor between NUM_REQ requesters; an ID FIFO routes results back.
// Define DUMMY_ARBITER_MODE_FENCE_EN to keep requests of a different mode out until in-flight ops drain.
package dummy_arbiter_pkg;
  typedef enum logic [0:0] {
    MODE_PIPE = 1'b0,
    MODE_ITER = 1'b1
  } coproc_ctl_t;
endpackage

module dummy_arbiter
  import dummy_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int DATA_W   = 32,
  parameter int ID_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic        [NUM_REQ-1:0]             req_valid_i,
  output logic        [NUM_REQ-1:0]             req_ready_o,
  input  coproc_ctl_t [NUM_REQ-1:0]             req_ctl_i,
  input  logic        [NUM_REQ-1:0][DATA_W-1:0] req_op_i,
  output logic        [NUM_REQ-1:0]             rsp_valid_o,
  input  logic        [NUM_REQ-1:0]             rsp_ready_i,
  output logic        [DATA_W-1:0]              rsp_res_o,
  output logic                             cop_valid_o,
  input  logic                             cop_ready_i,
  output coproc_ctl_t                      cop_ctl_o,
  output logic        [DATA_W-1:0]              cop_op_o,
  input  logic                             cop_valid_i,
  output logic                             cop_ready_o,
  input  logic        [DATA_W-1:0]              cop_res_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW    = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]         state_q;
  logic [IDX_W-1:0]   lock_q;
  logic [IDX_W-1:0]   rr_q;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [IDX_W:0]     rr_sum;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] fence_ok;
  logic [NUM_REQ-1:0] issuable;

  logic [IDX_W-1:0]   id_mem [ID_DEPTH];
  logic [AW-1:0]      wr_q;
  logic [AW-1:0]      rd_q;
  logic [AW:0]        cnt_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [IDX_W-1:0]   head;

  // Full/empty come from registered occupancy, so a same-cycle pop never frees a slot early.
  assign fifo_full  = (cnt_q == (AW + 1)'(ID_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign head       = id_mem[rd_q];

`ifdef DUMMY_ARBITER_MODE_FENCE_EN
  coproc_ctl_t mode_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      fence_ok[i] = fifo_empty || (req_ctl_i[i] == mode_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= MODE_PIPE;
    end else if (push) begin
      mode_q <= cop_ctl_o;
    end
  end
`else
  assign fence_ok = '1;
`endif

  assign issuable = req_valid_i & fence_ok & {NUM_REQ{~fifo_full}};

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_q;
    rr_sum    = '0;
    cand      = '0;
    if (state_q == ST_HOLD) begin
      grant_vld = 1'b1;
      grant_idx = lock_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        rr_sum = {1'b0, rr_q} + (IDX_W + 1)'(k);
        if (rr_sum >= (IDX_W + 1)'(NUM_REQ)) rr_sum = rr_sum - (IDX_W + 1)'(NUM_REQ);
        cand = rr_sum[IDX_W-1:0];
        if (!grant_vld && issuable[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  assign cop_valid_o = grant_vld;
  assign cop_ctl_o   = req_ctl_i[grant_idx];
  assign cop_op_o    = req_op_i[grant_idx];
  assign push        = grant_vld && cop_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (push) req_ready_o[grant_idx] = 1'b1;
  end

  // Responses return in issue order; only the FIFO head may see the coprocessor result.
  always_comb begin
    rsp_valid_o = '0;
    cop_ready_o = 1'b0;
    if (!fifo_empty) begin
      rsp_valid_o[head] = cop_valid_i;
      cop_ready_o       = rsp_ready_i[head];
    end
  end

  assign rsp_res_o = cop_res_i;
  assign pop       = cop_valid_i && cop_ready_o;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ARB;
      lock_q  <= '0;
      rr_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else if (flush_i) begin
      state_q <= ST_ARB;
      rr_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (grant_vld && !cop_ready_i) begin
            state_q <= ST_HOLD;
            lock_q  <= grant_idx;
          end
        end
        ST_HOLD: begin
          if (cop_ready_i) state_q <= ST_ARB;
        end
        default: state_q <= ST_ARB;
      endcase

      if (push) begin
        wr_q <= wr_q + 1'b1;
        rr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;

      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // NOTE: the ID storage has no reset; entries are only meaningful below cnt_q, which is reset.
  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_q] <= grant_idx;
  end

endmodule
